mod_avg_filter_p: RTL and testbench

//  Parametrised boxcar averaging filter for ADC/sensor sample streams in the FOC datapath.
//  Two modes, selectable at run time:
//   - Block (decimating) mode: one output per 2^LOG2_N accepted samples.
//   - Sliding (moving) mode: one output per accepted sample once the window is full.

---
 rtl/filt_pkg.sv | 41 ++++
 rtl/mod_filter_dline.sv | 24 ++
 rtl/mod_avg_filter_p.sv | 124 ++++++++++++
 tb/tb_mod_avg_filter_p.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/filt_pkg.sv
// Shared constants and helpers for the boxcar averaging filter.
// FILTER_ROUND_EN selects round-half-up with saturation instead of truncation.
package filt_pkg;

    localparam logic MODE_BLOCK = 1'b0;
    localparam logic MODE_SLIDE = 1'b1;

    function automatic int acc_w(input int dw, input int l2n);
        return dw + l2n;
    endfunction

    // acc arrives already sign/zero extended to 64 bits by the caller
    function automatic logic [63:0] avg_shift(
        input logic [63:0] acc,
        input int          l2n,
        input int          dw,
        input logic        sgn
    );
        logic [63:0] s;
        logic [63:0] r;
`ifdef FILTER_ROUND_EN
        logic [63:0] mx;
`endif
        s = acc;
`ifdef FILTER_ROUND_EN
        s = s + (64'd1 << (l2n - 1));
`endif
        r = sgn ? 64'($signed(s) >>> l2n) : (s >> l2n);
`ifdef FILTER_ROUND_EN
        mx = sgn ? ((64'd1 << (dw - 1)) - 64'd1)
                 : ((64'd1 << dw) - 64'd1);
        if (sgn ? ($signed(r) > $signed(mx)) : (r > mx))
            r = mx;
`else
        if (dw < 0)
            r = '0;
`endif
        return r;
    endfunction

endpackage

// File: rtl/mod_filter_dline.sv
// Single-port delay-line RAM with synchronous read-before-write.
import filt_pkg::*;

module mod_filter_dline #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic [LOG2_N-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [0:(1<<LOG2_N)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            dout      <= mem[addr];
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/mod_avg_filter_p.sv
// Boxcar averaging filter, block (decimating) or sliding mode.
// Output rounding is selected by FILTER_ROUND_EN (see filt_pkg).
import filt_pkg::*;

module mod_avg_filter_p #(
    parameter int DATA_W    = 16,
    parameter int LOG2_N    = 10,
    parameter int IS_SIGNED = 0
) (
    input  logic              pClk,
    input  logic              pRst,
    input  logic              pMode,
    input  logic              pClr,
    input  logic              pInVld,
    input  logic [DATA_W-1:0] pFilterIn,
    output logic [DATA_W-1:0] pFilterOut,
    output logic              pOutVld,
    output logic              pFull
);

    localparam int ACC_W = acc_w(DATA_W, LOG2_N);
    localparam int N     = 1 << LOG2_N;
    localparam logic SX  = (IS_SIGNED != 0);
    localparam logic [LOG2_N-1:0] CNT_MAX = LOG2_N'(N - 1);
    localparam logic [LOG2_N:0]   FILL_N  = (LOG2_N+1)'(N);
    localparam logic [LOG2_N:0]   FILL_N1 = (LOG2_N+1)'(N - 1);

    function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] d);
        return {{LOG2_N{SX & d[DATA_W-1]}}, d};
    endfunction

    function automatic logic [DATA_W-1:0] avg(input logic [ACC_W-1:0] a);
        return DATA_W'(avg_shift({{(64-ACC_W){SX & a[ACC_W-1]}}, a},
                                 LOG2_N, DATA_W, SX));
    endfunction

    logic              mode_q;
    logic              flush;
    logic              slide;
    logic              take;
    logic [ACC_W-1:0]  acc;
    logic [LOG2_N-1:0] cnt;
    logic [LOG2_N-1:0] wr_ptr;
    logic [LOG2_N:0]   fill;
    logic              s1_vld;
    logic              s1_sub;
    logic              s1_out;
    logic [DATA_W-1:0] s1_x;
    logic              s2_vld;
    logic [DATA_W-1:0] x_old;

    // a mode change behaves exactly like pClr for that cycle
    assign flush = pClr | (pMode != mode_q);
    assign slide = (pMode == MODE_SLIDE);
    assign take  = pInVld & ~flush;
    assign pFull = (fill == FILL_N);

    mod_filter_dline #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_dline (
        .clk  (pClk),
        .en   (take & slide),
        .addr (wr_ptr),
        .din  (pFilterIn),
        .dout (x_old)
    );

    always_ff @(posedge pClk) begin
        mode_q <= pMode;
        if (pRst) begin
            acc        <= '0;
            cnt        <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
            s1_vld     <= 1'b0;
            s1_sub     <= 1'b0;
            s1_out     <= 1'b0;
            s1_x       <= '0;
            s2_vld     <= 1'b0;
            pFilterOut <= '0;
            pOutVld    <= 1'b0;
        end else if (flush) begin
            acc     <= '0;
            cnt     <= '0;
            wr_ptr  <= '0;
            fill    <= '0;
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            pOutVld <= 1'b0;
        end else begin
            pOutVld <= 1'b0;
            s1_vld  <= take & slide;
            s2_vld  <= s1_vld & s1_out;
            if (take & slide) begin
                s1_x   <= pFilterIn;
                s1_sub <= (fill == FILL_N);
                s1_out <= (fill >= FILL_N1);
                wr_ptr <= wr_ptr + 1'b1;
                if (fill != FILL_N)
                    fill <= fill + 1'b1;
            end
            // x_old is the RAM word read when s1 was accepted
            if (s1_vld)
                acc <= acc + ext(s1_x) - (s1_sub ? ext(x_old) : '0);
            if (s2_vld) begin
                pFilterOut <= avg(acc);
                pOutVld    <= 1'b1;
            end
            if (take & ~slide) begin
                if (cnt == CNT_MAX) begin
                    pFilterOut <= avg(acc + ext(pFilterIn));
                    pOutVld    <= 1'b1;
                    acc        <= '0;
                    cnt        <= '0;
                end else begin
                    acc <= acc + ext(pFilterIn);
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_avg_filter_p.sv
// Self-checking bench for mod_avg_filter_p: vector table, hand sequences
// and a random scoreboard run on a 1024-sample window.
module tb_mod_avg_filter_p;

    typedef struct {
        logic        mode;
        logic        clr;
        logic        vld;
        logic [15:0] din;
        logic        push;
        logic [15:0] exp;
        logic        full;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, mode, clr, vld;
    logic [15:0] din;
    logic [15:0] out0, out1, out2;
    logic        ov0, ov1, ov2;
    logic        full0, full1, full2;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          sel = 0;
    logic [15:0] q[$];
    vec_t        tbl[$];

    always #5 clk = ~clk;

    mod_avg_filter_p #(.DATA_W(16), .LOG2_N(2), .IS_SIGNED(0)) u0 (
        .pClk(clk), .pRst(rst), .pMode(mode), .pClr(clr), .pInVld(vld),
        .pFilterIn(din), .pFilterOut(out0), .pOutVld(ov0), .pFull(full0));

    mod_avg_filter_p #(.DATA_W(16), .LOG2_N(2), .IS_SIGNED(1)) u1 (
        .pClk(clk), .pRst(rst), .pMode(mode), .pClr(clr), .pInVld(vld),
        .pFilterIn(din), .pFilterOut(out1), .pOutVld(ov1), .pFull(full1));

    mod_avg_filter_p #(.DATA_W(16), .LOG2_N(10), .IS_SIGNED(0)) u2 (
        .pClk(clk), .pRst(rst), .pMode(mode), .pClr(clr), .pInVld(vld),
        .pFilterIn(din), .pFilterOut(out2), .pOutVld(ov2), .pFull(full2));

    function automatic logic [15:0] model(input longint sum, input int l2n,
                                          input bit sgn);
        longint r;
        longint mx;
        r = sum;
`ifdef FILTER_ROUND_EN
        r = r + (longint'(1) << (l2n - 1));
`endif
        r  = r >>> l2n;
        mx = sgn ? 64'sd32767 : 64'sd65535;
        if (r > mx)
            r = mx;
        return r[15:0];
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic        v;
        logic [15:0] o;
        logic [15:0] e;
        v = (sel == 0) ? ov0 : (sel == 1) ? ov1 : ov2;
        o = (sel == 0) ? out0 : (sel == 1) ? out1 : out2;
        if (v) begin
            if (q.size() == 0) begin
                check("unexpected_outvld", 1, 0);
            end else begin
                e = q.pop_front();
                check("out", o, e);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
    endtask

    task automatic add(input logic m, input logic c, input logic v,
                       input logic [15:0] d, input logic p,
                       input logic [15:0] e, input logic f);
        vec_t r;
        r = '{mode: m, clr: c, vld: v, din: d, push: p, exp: e, full: f};
        tbl.push_back(r);
    endtask

    initial begin
        longint win[$];
        longint sum;
        longint bsum;
        int     bcnt;
        rst = 1'b1; mode = 1'b0; clr = 1'b0; vld = 1'b0; din = '0;

        // basic block mode
        add(0,0,1,10,0,0,0); add(0,0,1,20,0,0,0); add(0,0,1,30,0,0,0);
        add(0,0,1,41,1,model(101,2,0),0);
        // clear mid-block, dropped sample under clr
        add(0,0,1,50,0,0,0); add(0,0,1,60,0,0,0); add(0,1,1,999,0,0,0);
        add(0,0,1,100,0,0,0); add(0,0,1,100,0,0,0); add(0,0,1,100,0,0,0);
        add(0,0,1,100,1,model(400,2,0),0);
        // switch to sliding, back-to-back samples
        add(1,0,1,7,0,0,0);
        add(1,0,1,4,0,0,0); add(1,0,1,8,0,0,0); add(1,0,1,12,0,0,0);
        add(1,0,1,16,1,model(40,2,0),1); add(1,0,1,20,1,model(56,2,0),1);
        // two samples in flight killed by mode toggle
        add(1,0,1,24,0,0,1); add(1,0,1,28,0,0,1); add(0,0,1,33,0,0,0);
        add(0,0,1,40,0,0,0); add(0,0,1,40,0,0,0); add(0,0,1,40,0,0,0);
        add(0,0,1,44,1,model(164,2,0),0);
        // refill a sliding window before the reset check
        add(1,0,1,7,0,0,0);
        add(1,0,1,5,0,0,0); add(1,0,1,5,0,0,0); add(1,0,1,5,0,0,0);
        add(1,0,1,5,1,model(20,2,0),1);
        add(1,0,0,0,0,0,1); add(1,0,0,0,0,0,1); add(1,0,0,0,0,0,1);

        repeat (3) step();
        check("rst_out", out0, 0);
        check("rst_outvld", ov0, 0);
        check("rst_full", full0, 0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            mode = tbl[i].mode;
            clr  = tbl[i].clr;
            vld  = tbl[i].vld;
            din  = tbl[i].din;
            if (tbl[i].push)
                q.push_back(tbl[i].exp);
            step();
            check($sformatf("full_row%0d", i), full0, tbl[i].full);
        end
        check("tbl_drain", q.size(), 0);

        // reset mid-window with a live sample
        rst = 1'b1; vld = 1'b1; din = 16'd9;
        step();
        check("midrst_out", out0, 0);
        check("midrst_outvld", ov0, 0);
        check("midrst_full", full0, 0);

        // signed block average with truncation toward -inf
        sel = 1; mode = 1'b0; vld = 1'b0;
        step();
        rst = 1'b0;
        vld = 1'b1;
        din = 16'hFFFD; step();
        din = 16'hFFFD; step();
        din = 16'hFFFD; step();
        din = 16'hFFFE; q.push_back(model(-11,2,1)); step();
        vld = 1'b0;
        repeat (3) step();
        check("signed_drain", q.size(), 0);
        check("signed_full", full1, 0);

        // random sliding run on the 1024-sample window
        sel = 2; rst = 1'b1; mode = 1'b1;
        step();
        rst = 1'b0;
        sum = 0;
        for (int i = 0; i < 3000; i++) begin
            vld = ($urandom_range(0, 4) != 0);
            din = 16'($urandom_range(0, 65535));
            if (vld) begin
                win.push_back(longint'(din));
                sum += longint'(din);
                if (win.size() > 1024)
                    sum -= win.pop_front();
                if (win.size() == 1024)
                    q.push_back(model(sum, 10, 0));
            end
            step();
        end
        vld = 1'b0;
        repeat (4) step();
        check("slide_full", full2, 1);
        check("slide_drain", q.size(), 0);

        // random block run after a mode change
        mode = 1'b0;
        step();
        check("block_full", full2, 0);
        bsum = 0; bcnt = 0;
        for (int i = 0; i < 2600; i++) begin
            vld = ($urandom_range(0, 4) != 0);
            din = 16'($urandom_range(0, 65535));
            if (vld) begin
                bsum += longint'(din);
                bcnt++;
                if (bcnt == 1024) begin
                    q.push_back(model(bsum, 10, 0));
                    bsum = 0; bcnt = 0;
                end
            end
            step();
        end
        vld = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++)
            step();
        check("final_drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
